// File: rtl/fir_ctrl_pkg.sv
// Shared constants and state encoding for the FIR sequencer/config front-end.
// Imported by fir_direct_ctrl and fir_rate_pacer.
package fir_ctrl_pkg;

   localparam int NTAP = 33;
   localparam int DIVW = 8;
   localparam int DW   = 16;
   localparam int AW   = 6;

   localparam logic [AW-1:0] ADDR_COEF_LAST = AW'(NTAP - 1);
   localparam logic [AW-1:0] ADDR_CTRL      = 6'h21;
   localparam logic [AW-1:0] ADDR_DIV       = 6'h22;
   localparam logic [AW-1:0] ADDR_STATUS    = 6'h23;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_CLR_ERR = 1;

   localparam int ST_BUSY   = 0;
   localparam int ST_WR_ERR = 1;

   localparam int FCW = $clog2(NTAP - 1);
   localparam logic [FCW-1:0] FLUSH_LAST = FCW'(NTAP - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FLUSH = 2'd1,
      S_RUN   = 2'd2
   } state_t;

endpackage

// File: rtl/fir_rate_pacer.sv
// Sample-rate pacer: a down-counter reloaded on every accepted sample.
// A divider of 0 or 1 both give back-to-back accepts.
import fir_ctrl_pkg::*;

module fir_rate_pacer (
   input  logic            i_clk,
   input  logic            i_rsn,
   input  logic            i_en,
   input  logic            i_accept,
   input  logic [DIVW-1:0] i_div,
   output logic            o_ready
);

   logic [DIVW-1:0] r_cnt;
   logic [DIVW-1:0] w_load;

   assign w_load  = (i_div > DIVW'(1)) ? i_div : '0;
   assign o_ready = i_en && (r_cnt == '0);

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         r_cnt <= '0;
      end else if (!i_en) begin
         r_cnt <= '0;
      end else if (i_accept) begin
         r_cnt <= w_load;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - DIVW'(1);
      end
   end

endmodule

// File: rtl/fir_direct_ctrl.sv
// Register bank, flush/run sequencer and output pipeline that feed
// the 33-tap direct-form FIR core.
import fir_ctrl_pkg::*;

module fir_direct_ctrl (
   input  logic                 iClk_12M,
   input  logic                 iRsn,
   input  logic                 iCsn,
   input  logic                 iWrn,
   input  logic [AW-1:0]        iAddr,
   input  logic [DW-1:0]        iWrDt,
   output logic [DW-1:0]        oRdDt,
   input  logic                 iInValid,
   input  logic signed [DW-1:0] iInData,
   output logic                 oInReady,
   output logic                 oEnAcc,
   output logic signed [DW-1:0] oFirIn,
   output logic [NTAP*DW-1:0]   oCoeff,
   output logic                 oOutValid,
   output logic                 oBusy
);

   state_t r_state;
   state_t w_state_nxt;

   logic [DW-1:0]        r_coeff [NTAP];
   logic [DIVW-1:0]      r_div;
   logic                 r_run;
   logic                 r_err;
   logic [FCW-1:0]       r_fcnt;
   logic                 r_en_run;
   logic                 r_out_valid;
   logic signed [DW-1:0] r_fir_in;
   logic [DW-1:0]        r_rd_dt;

   logic          w_wr;
   logic          w_rd;
   logic          w_sel_coef;
   logic          w_sel_ctrl;
   logic          w_sel_div;
   logic          w_sel_stat;
   logic          w_idle;
   logic          w_wr_bad;
   logic          w_ready;
   logic          w_accept;
   logic          w_pace_en;
   logic          w_flush_last;
   logic [DW-1:0] w_status;
   logic [DW-1:0] w_rd_mux;

   assign w_wr       = !iCsn && !iWrn;
   assign w_rd       = !iCsn && iWrn;
   assign w_sel_coef = iAddr <= ADDR_COEF_LAST;
   assign w_sel_ctrl = iAddr == ADDR_CTRL;
   assign w_sel_div  = iAddr == ADDR_DIV;
   assign w_sel_stat = iAddr == ADDR_STATUS;
   assign w_idle     = r_state == S_IDLE;
   assign w_wr_bad   = w_wr && (w_sel_coef || w_sel_div) && !w_idle;

   assign w_status     = {12'd0, r_state, r_err, !w_idle};
   assign w_flush_last = r_fcnt == FLUSH_LAST;
   assign w_pace_en    = (r_state == S_RUN) && r_run;
   assign w_accept     = iInValid && w_ready;

   fir_rate_pacer u_pacer (
      .i_clk    (iClk_12M),
      .i_rsn    (iRsn),
      .i_en     (w_pace_en),
      .i_accept (w_accept),
      .i_div    (r_div),
      .o_ready  (w_ready)
   );

   always_comb begin
      w_rd_mux = '0;
      unique case (1'b1)
         w_sel_coef: w_rd_mux = r_coeff[iAddr];
         w_sel_ctrl: w_rd_mux = {15'd0, r_run};
         w_sel_div:  w_rd_mux = DW'(r_div);
         w_sel_stat: w_rd_mux = w_status;
         default:    w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         for (int i = 0; i < NTAP; i++) r_coeff[i] <= '0;
      end else if (w_wr && w_sel_coef && w_idle) begin
         r_coeff[iAddr] <= iWrDt;
      end
   end

   // An error-causing write wins over a clear in the same cycle.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         r_div   <= '0;
         r_run   <= 1'b0;
         r_err   <= 1'b0;
         r_rd_dt <= '0;
      end else begin
         if (w_wr && w_sel_div && w_idle) r_div <= iWrDt[DIVW-1:0];
         if (w_wr && w_sel_ctrl) r_run <= iWrDt[CTRL_RUN];
         if (w_wr_bad) begin
            r_err <= 1'b1;
         end else if (w_wr && w_sel_ctrl && iWrDt[CTRL_CLR_ERR]) begin
            r_err <= 1'b0;
         end
         if (w_rd) r_rd_dt <= w_rd_mux;
      end
   end

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (r_run) w_state_nxt = S_FLUSH;
         S_FLUSH: if (w_flush_last) w_state_nxt = r_run ? S_RUN : S_IDLE;
         S_RUN:   if (!r_run) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         r_fcnt <= '0;
      end else if ((r_state == S_FLUSH) && !w_flush_last) begin
         r_fcnt <= r_fcnt + FCW'(1);
      end else begin
         r_fcnt <= '0;
      end
   end

   // Flush strobes zero the sample register so the core shifts in zeros.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         r_en_run    <= 1'b0;
         r_out_valid <= 1'b0;
         r_fir_in    <= '0;
      end else begin
         r_en_run    <= w_accept;
         r_out_valid <= r_en_run;
         if (w_accept) begin
            r_fir_in <= iInData;
         end else if (w_state_nxt == S_FLUSH) begin
            r_fir_in <= '0;
         end
      end
   end

   for (genvar k = 0; k < NTAP; k++) begin : g_coef
      assign oCoeff[DW*k +: DW] = r_coeff[k];
   end

   assign oRdDt     = r_rd_dt;
   assign oInReady  = w_ready;
   assign oEnAcc    = (r_state == S_FLUSH) || r_en_run;
   assign oFirIn    = r_fir_in;
   assign oOutValid = r_out_valid;
   assign oBusy     = !w_idle;

endmodule
